// File: rtl/ps2_transmitter_if.sv
// Controller handshake plus the PS/2 clock/data line pair seen by ps2_transmitter.
// The "slave" modport is the transmitter; "master" is the controller/line side.
interface ps2_transmitter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_start, tx_data, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, busy, done, err
  );

  modport slave (
    input  tx_start, tx_data, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, busy, done, err
  );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then clock out one
// odd-parity frame on device-generated falling edges and check the device ACK.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  ps2_transmitter_if.slave bus
);
  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ack_ok_q, ack_ok_d;
  logic            ps2c_oe_q, ps2c_oe_d;
  logic            ps2d_oe_q, ps2d_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic ps2c_p0_q, ps2c_p1_q, ps2c_p2_q;
  logic ps2d_p0_q, ps2d_p1_q;
  logic fe_c, line_idle, tracked, abort;

  assign fe_c      = ps2c_p2_q & ~ps2c_p1_q;
  assign line_idle = ps2c_p1_q & ps2d_p1_q;
  assign tracked   = state_q inside {S_SEND, S_ACK, S_WAIT_IDLE};
  // A falling edge or a clean finish in the same cycle wins over the timeout.
  assign abort     = tracked && !fe_c && !(state_q == S_WAIT_IDLE && line_idle) &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    ph_cnt_d  = ph_cnt_q;
    to_cnt_d  = to_cnt_q;
    ack_ok_d  = ack_ok_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (bus.tx_start) begin
          data_d    = bus.tx_data;
          par_d     = ~^bus.tx_data;
          ack_ok_d  = 1'b0;
          ph_cnt_d  = '0;
          ps2c_oe_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (ph_cnt_q == PH_W'(INHIBIT_CYCLES - 1)) begin
          ph_cnt_d  = '0;
          ps2d_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_RTS: begin
        if (ph_cnt_q == PH_W'(RTS_CYCLES - 1)) begin
          ps2c_oe_d = 1'b0;
          bit_idx_d = '0;
          to_cnt_d  = '0;
          state_d   = S_SEND;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fe_c) begin
          to_cnt_d  = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            ps2d_oe_d = ~data_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            ps2d_oe_d = ~par_q;
          end else begin
            ps2d_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fe_c) begin
          to_cnt_d = '0;
          ack_ok_d = ~ps2d_p1_q;
          state_d  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        to_cnt_d = fe_c ? '0 : to_cnt_q + TO_W'(1);
        if (line_idle) begin
          busy_d  = 1'b0;
          done_d  = ack_ok_q;
          err_d   = ~ack_ok_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      ps2c_oe_d = 1'b0;
      ps2d_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      to_cnt_d  = '0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_idx_q <= '0;
      ph_cnt_q  <= '0;
      to_cnt_q  <= '0;
      ack_ok_q  <= 1'b0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ps2c_p0_q <= 1'b1;
      ps2c_p1_q <= 1'b1;
      ps2c_p2_q <= 1'b1;
      ps2d_p0_q <= 1'b1;
      ps2d_p1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      ph_cnt_q  <= ph_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ack_ok_q  <= ack_ok_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ps2c_p0_q <= bus.ps2c_in;
      ps2c_p1_q <= ps2c_p0_q;
      ps2c_p2_q <= ps2c_p1_q;
      ps2d_p0_q <= bus.ps2d_in;
      ps2d_p1_q <= ps2d_p0_q;
    end
  end

  assign bus.ps2c_oe = ps2c_oe_q;
  assign bus.ps2d_oe = ps2d_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, echo 0xEE, ...) from the FPGA to the keyboard over the same ps2c/ps2d lines the piano's receive path listens on. It drives both lines open-drain via active-high output enables, follows the device-generated clock bit by bit, checks the device's ACK bit, and reports done or error to the controller.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles ps2c is held low before request-to-send (100 us at 50 MHz)
RTS_CYCLES, 50, CLK cycles ps2c and ps2d are both held low before ps2c is released
TIMEOUT_CYCLES, 1_000_000, max CLK cycles allowed between device falling edges, or while waiting for bus idle, before aborting

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
tx_start  in  1  one-cycle request; sampled only when busy=0
tx_data  in  8  byte to send; latched in the cycle tx_start is accepted
ps2c_in  in  1  raw PS/2 clock line (asynchronous)
ps2d_in  in  1  raw PS/2 data line (asynchronous)
ps2c_oe  out  1  1 = pull ps2c low; 0 = release
ps2d_oe  out  1  1 = pull ps2d low; 0 = release
busy  out  1  transfer in progress
done  out  1  one-cycle pulse: byte sent and ACK received
err  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset: state IDLE. ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0. Counters and shift register cleared. RST mid-transfer releases both lines on the next edge.
- Input sync: ps2c_in and ps2d_in each pass through a 2-FF synchronizer. A falling edge (fe) is prev_sync=1 and sync=0. The fe flag is 1 cycle wide.
- Parity: odd. par = ~^tx_data, computed at latch.
- Frame bit k is driven by setting ps2d_oe = ~bit.
- States:
  - IDLE: lines released, busy=0. On tx_start, latch data and parity, go to INHIBIT; busy=1 from the next cycle. tx_start while busy=1 is ignored. No queueing.
  - INHIBIT: ps2c_oe=1, ps2d_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: ps2c_oe=1, ps2d_oe=1 (start bit 0) for RTS_CYCLES cycles, then go to SEND with ps2c_oe=0, bit index 0, and the timeout counter cleared.
  - SEND: fe numbers 1..8 drive data bits 0..7 (LSB first). fe 9 drives the parity bit. fe 10 drives the stop bit (ps2d_oe=0). ps2d_oe changes in the cycle after the fe flag. After fe 10, go to ACK.
  - ACK: on the next fe, sample synchronized ps2d. 0 sets ack_ok; 1 sets nack. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized ps2c=1 and ps2d=1 in the same cycle, then go to IDLE. On that transition, pulse done if ack_ok, else pulse err. busy drops in the same cycle as the pulse.
- Timeout: in SEND, ACK and WAIT_IDLE the counter increments each cycle and clears on every fe. At count == TIMEOUT_CYCLES-1: release both lines, pulse err, go to IDLE.
- done and err are never asserted together.
- ps2c_oe is never 1 outside INHIBIT and RTS.
- A fe arriving in INHIBIT or RTS is ignored; the host is driving ps2c at that point.

Test Plan:
- Bench parameters: INHIBIT_CYCLES=20, RTS_CYCLES=4, TIMEOUT_CYCLES=200. Device model clocks at 40-cycle period.
- Normal send 0xED: ps2c_oe=1 for exactly 24 cycles. ps2d_oe=1 for the final 4 of those. After fe 1..10, ps2d_oe sequence = 0,1,0,0,1,0,0,0,0(parity 1),0(stop). Device ACKs with 0 → one done pulse, err=0, busy falls in the same cycle.
- Send 0x00: parity bit = 1, so ps2d_oe=0 at the parity slot; data slots all ps2d_oe=1 → done.
- NACK: device holds ps2d=1 at the 11th fe for byte 0xFF → single err pulse after the bus returns idle; done stays 0.
- Device stalls after fe 4 → exactly 200 cycles later err pulses, ps2c_oe=ps2d_oe=0, busy=0. A following tx_start is accepted normally.
- tx_start pulsed again during SEND with 0xAA → ignored; frame still carries the first byte; one done only.
- RST asserted in RTS → next cycle both oe=0, busy=0, no done/err. A new tx_start after RST completes normally.
